// File: rtl/aes_word_loader_if.sv
// Word-stream handshake into the AES loader: 32-bit words with a valid/ready pair
// and the per-block key-reuse hint.
interface aes_word_loader_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        key_reuse;

    modport master (
        output wr_valid,
        output wr_data,
        output key_reuse,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  key_reuse,
        output wr_ready
    );
endinterface

// File: rtl/aes_word_loader.sv
// Assembles 128-bit plaintext and key from a 32-bit word stream and holds them
// on AES_top's inputs until it reports completion or the hold timeout expires.
module aes_word_loader #(
    parameter int unsigned EN_HOLD_MAX = 64,
    parameter int unsigned CNT_W       = 7
) (
    input  logic               AES_clk,
    input  logic               AES_rst_n,
    aes_word_loader_if.slave   wr,
    input  logic               err_clr,
    input  logic               AES_data_out_valid,
    output logic               AES_en,
    output logic [127:0]       AES_data_in,
    output logic [127:0]       AES_key_in,
    output logic               busy,
    output logic               timeout_err
);

    localparam int unsigned    IDX_W     = 3;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(EN_HOLD_MAX - 1);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   hold_cnt;
    logic [IDX_W-1:0]   word_idx;
    logic               key_loaded;
    logic               reuse_latched;
    logic               last_word;

    // Word 3 closes the block only when the stored key is being reused.
    assign last_word = (word_idx == IDX_W'(7)) ||
                       ((word_idx == IDX_W'(3)) && reuse_latched);

    assign wr.wr_ready = (state == ST_LOAD);
    assign busy        = AES_en;

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state         <= ST_LOAD;
            hold_cnt      <= '0;
            word_idx      <= '0;
            key_loaded    <= 1'b0;
            reuse_latched <= 1'b0;
            AES_en        <= 1'b0;
            AES_data_in   <= '0;
            AES_key_in    <= '0;
            timeout_err   <= 1'b0;
        end else begin
            // A timeout set later in this block overrides a same-edge clear.
            if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                ST_LOAD: begin
                    if (wr.wr_valid) begin
                        if (word_idx[2] == 1'b0) begin
                            AES_data_in <= {AES_data_in[95:0], wr.wr_data};
                        end else begin
                            AES_key_in  <= {AES_key_in[95:0], wr.wr_data};
                        end

                        if (word_idx == IDX_W'(0)) begin
                            reuse_latched <= wr.key_reuse && key_loaded;
                        end

                        if (last_word) begin
                            state    <= ST_RUN;
                            AES_en   <= 1'b1;
                            hold_cnt <= '0;
                            word_idx <= '0;
                            if (word_idx == IDX_W'(7)) begin
                                key_loaded <= 1'b1;
                            end
                        end else begin
                            word_idx <= word_idx + IDX_W'(1);
                        end
                    end
                end

                ST_RUN: begin
                    // Completion takes priority over an expiring hold window.
                    if (AES_data_out_valid) begin
                        state  <= ST_LOAD;
                        AES_en <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state       <= ST_LOAD;
                        AES_en      <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state  <= ST_LOAD;
                    AES_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_word_loader.sv
// Randomized scoreboard bench for aes_word_loader: a block-level model predicts
// the plaintext/key presented at each RUN entry; directed checks cover timing edges.
module tb_aes_word_loader;

    localparam int unsigned HOLD = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         err_clr;
    logic         out_valid;
    logic         en;
    logic         busy;
    logic         terr;
    logic [127:0] din;
    logic [127:0] kin;

    aes_word_loader_if wr_if ();

    aes_word_loader #(.EN_HOLD_MAX(HOLD), .CNT_W(7)) dut (
        .AES_clk            (clk),
        .AES_rst_n          (rst_n),
        .wr                 (wr_if),
        .err_clr            (err_clr),
        .AES_data_out_valid (out_valid),
        .AES_en             (en),
        .AES_data_in        (din),
        .AES_key_in         (kin),
        .busy               (busy),
        .timeout_err        (terr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [127:0] data;
        logic [127:0] key;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         last_exp;
    logic [127:0] m_key;
    bit           m_key_loaded;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: each RUN entry must present the next predicted block.
    initial begin : monitor
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (en && !prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_run: got data %h expected no run", din);
                end else begin
                    e = exp_q.pop_front();
                    chk("run_data", din, e.data);
                    chk("run_key", kin, e.key);
                    chk("run_ready", 128'(wr_if.wr_ready), 128'd0);
                end
            end
            prev = en;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    // Present one word; returns at the negedge after the accepting edge.
    task automatic drive_word(input logic [31:0] d, input logic kr, input int gap);
        int t;
        if (gap > 0) begin
            wr_if.wr_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        wr_if.wr_valid  = 1'b1;
        wr_if.wr_data   = d;
        wr_if.key_reuse = kr;
        t = 0;
        while (!wr_if.wr_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!wr_if.wr_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_wait: got wr_ready 0 expected 1 within 200 cycles");
        end
        @(negedge clk);
    endtask

    task automatic send_words(input bit reuse, input logic [31:0] w [8], input int gap_max);
        bit   use_key;
        int   n;
        exp_t e;
        use_key = reuse && m_key_loaded;
        n = use_key ? 4 : 8;
        e.data = {w[0], w[1], w[2], w[3]};
        e.key  = use_key ? m_key : {w[4], w[5], w[6], w[7]};
        if (!use_key) begin
            m_key        = e.key;
            m_key_loaded = 1'b1;
        end
        exp_q.push_back(e);
        last_exp = e;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) chk("en_before_last", 128'(en), 128'd0);
            drive_word(w[i], (i == 0) ? reuse : 1'($urandom_range(0, 1)),
                       $urandom_range(0, gap_max));
        end
        wr_if.wr_valid = 1'b0;
        chk("en_after_last", 128'(en), 128'd1);
        chk("busy_after_last", 128'(busy), 128'd1);
    endtask

    task automatic send_random(input bit reuse, input int gap_max);
        logic [31:0] w [8];
        for (int i = 0; i < 8; i++) w[i] = 32'($urandom);
        send_words(reuse, w, gap_max);
    endtask

    // Called at the negedge after RUN entry (hold count 0); completes at count `hold`.
    task automatic finish_run(input int hold);
        repeat (hold) begin
            wr_if.wr_valid = 1'($urandom_range(0, 1));
            wr_if.wr_data  = 32'($urandom);
            @(negedge clk);
        end
        chk("en_held", 128'(en), 128'd1);
        wr_if.wr_valid = 1'b0;
        out_valid = 1'b1;
        @(negedge clk);
        out_valid = 1'b0;
        chk("en_fall", 128'(en), 128'd0);
        chk("ready_after_run", 128'(wr_if.wr_ready), 128'd1);
        chk("data_kept", din, last_exp.data);
        chk("key_kept", kin, last_exp.key);
    endtask

    task automatic run_timeout();
        int cyc;
        cyc = 0;
        wr_if.wr_valid = 1'b0;
        while (en && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        chk("en_high_cycles", 128'(cyc), 128'(HOLD));
        chk("timeout_set", 128'(terr), 128'd1);
        chk("ready_after_timeout", 128'(wr_if.wr_ready), 128'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("timeout_cleared", 128'(terr), 128'd0);
    endtask

    task automatic reset_now(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_en"}, 128'(en), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_data"}, din, 128'd0);
        chk({tag, "_key"}, kin, 128'd0);
        chk({tag, "_terr"}, 128'(terr), 128'd0);
        chk({tag, "_ready"}, 128'(wr_if.wr_ready), 128'd1);
        m_key_loaded = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : stimulus
        logic [31:0] w [8];
        rst_n           = 1'b0;
        err_clr         = 1'b0;
        out_valid       = 1'b0;
        wr_if.wr_valid  = 1'b0;
        wr_if.wr_data   = '0;
        wr_if.key_reuse = 1'b0;
        m_key_loaded    = 1'b0;
        m_key           = '0;
        repeat (2) @(negedge clk);
        chk("rst_en", 128'(en), 128'd0);
        chk("rst_data", din, 128'd0);
        chk("rst_key", kin, 128'd0);
        chk("rst_terr", 128'(terr), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 128'(wr_if.wr_ready), 128'd1);

        // Known-answer block, completion at hold count 20.
        w = '{32'h000000c0, 32'h0, 32'h0, 32'h0,
              32'haa2bdb40, 32'hbff6a5e8, 32'hcaa9ba3e, 32'hbc1e2acc};
        send_words(1'b0, w, 0);
        chk("kat_data", din, 128'h000000c0_00000000_00000000_00000000);
        chk("kat_key", kin, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
        finish_run(20);

        // Key reuse: four words only.
        w = '{32'ha6f2daeb, 32'h140fa720, 32'h529e75d5, 32'h21cbc681,
              32'h0, 32'h0, 32'h0, 32'h0};
        send_words(1'b1, w, 0);
        chk("reuse_data", din, 128'ha6f2daeb_140fa720_529e75d5_21cbc681);
        chk("reuse_key", kin, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
        finish_run(5);

        // No completion: hold timeout.
        send_random(1'b1, 1);
        run_timeout();

        // Completion on the timeout edge wins, then stray valid in LOAD.
        send_random(1'b0, 0);
        finish_run(HOLD - 1);
        chk("valid_beats_timeout", 128'(terr), 128'd0);
        out_valid = 1'b1;
        repeat (3) @(negedge clk);
        out_valid = 1'b0;
        chk("load_valid_en", 128'(en), 128'd0);
        chk("load_valid_ready", 128'(wr_if.wr_ready), 128'd1);

        // Randomized blocks.
        for (int b = 0; b < 14; b++) begin
            send_random(1'($urandom_range(0, 1)), 2);
            if (b % 5 == 4) run_timeout();
            else finish_run($urandom_range(0, 40));
        end

        // Reset after five words of a load.
        for (int i = 0; i < 5; i++) drive_word(32'($urandom), 1'b0, 0);
        wr_if.wr_valid = 1'b0;
        reset_now("rst_load");
        send_random(1'b1, 0);
        finish_run(3);

        // Reset in the middle of RUN.
        send_random(1'b0, 0);
        repeat (7) @(negedge clk);
        reset_now("rst_run");
        send_random(1'b1, 1);
        finish_run(10);
        send_random(1'b1, 0);
        finish_run(2);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_word_loader.md
# aes_word_loader

Upstream feeder for `AES_top`. It assembles the 128-bit plaintext and 128-bit cipher key from a 32-bit valid/ready word stream and drives `AES_en`, `AES_data_in` and `AES_key_in`. It holds them stable until `AES_top` reports `AES_data_out_valid`, or until a hold timeout expires. A key-reuse option lets back-to-back blocks under one key load only four data words.

## Interface
- `EN_HOLD_MAX`, default 64: maximum number of cycles `AES_en` stays high waiting for `AES_data_out_valid`; legal range 2..127.
- `CNT_W`, default 7: width of the hold counter; must satisfy 2^CNT_W > EN_HOLD_MAX.

Ports:
- `AES_clk` in 1: single clock, rising edge.
- `AES_rst_n` in 1: asynchronous, active-low reset (already decided).
- `wr_valid` in 1: word-stream valid.
- `wr_ready` out 1: word-stream ready; high only in LOAD.
- `wr_data` in 32: word payload; MS word first.
- `key_reuse` in 1: sampled on acceptance of word 0 only.
- `err_clr` in 1: clears `timeout_err`.
- `AES_data_out_valid` in 1: completion indication from `AES_top`.
- `AES_en` out 1: registered enable to `AES_top`.
- `AES_data_in` out 128: assembled plaintext, registered.
- `AES_key_in` out 128: assembled key, registered.
- `busy` out 1: equals `AES_en`.
- `timeout_err` out 1: sticky timeout flag.

## Operation
- States are LOAD and RUN.
- Reset values: LOAD; `AES_en`=0, `busy`=0, `timeout_err`=0, `AES_data_in`=0, `AES_key_in`=0, word index=0, key_loaded=0, reuse_latched=0. `wr_ready`=1 immediately after reset release.
- A word is accepted on a rising edge with `wr_valid && wr_ready`. Word index counts 0..7.
- Words 0-3 shift into `AES_data_in`: `{AES_data_in[95:0], wr_data}`.
- Words 4-7 shift into `AES_key_in` the same way.
- At word 0 acceptance, reuse_latched = `key_reuse && key_loaded`.
  - If reuse_latched=1, word 3 is the last word and the key is untouched.
  - Otherwise word 7 is the last word, and key_loaded is set on its acceptance.
- `key_reuse` with key_loaded=0 is ignored: all 8 words are required.
- Accepting the last word:
  - transitions to RUN, sets `AES_en`=1, clears the hold counter, resets word index to 0;
  - `wr_ready` drops combinationally in RUN.
- RUN:
  - `AES_data_in` and `AES_key_in` are frozen.
  - The hold counter increments each cycle, saturating at EN_HOLD_MAX-1.
- RUN exit on valid: `AES_data_out_valid`=1 at an edge gives LOAD and `AES_en`=0 after that edge.
- RUN exit on timeout: an edge with counter == EN_HOLD_MAX-1 and no valid gives LOAD, `AES_en`=0, `timeout_err`=1.
- Simultaneous events:
  - Valid and timeout on the same edge: valid wins, `timeout_err` unchanged.
  - `err_clr` and a timeout on the same edge: set wins.
- `AES_data_out_valid` in LOAD is ignored.
- Output registers keep their last contents after RUN until overwritten by new words.
- Reset mid-operation, in any state: asynchronous clear to the reset values above. `AES_en` falls without waiting for a clock edge, and the partial word count and key_loaded are lost.

## Timing
- Last word accepted at edge N: `AES_en`=1 and `wr_ready`=0 in cycle N..N+1.
- `AES_data_out_valid` seen at edge M: `AES_en`=0 and `wr_ready`=1 from edge M.
  - The next word can be accepted at edge M+1.
- Maximum `AES_en` high time is EN_HOLD_MAX cycles.
- Full 8-word load with `wr_valid` held high takes 8 cycles. A reuse load takes 4 cycles.
- Throughput is not back-to-back: at least one LOAD cycle per word separates RUN periods.

## Test plan
- Reset, then 8 words 000000c0, 0, 0, 0, aa2bdb40, bff6a5e8, caa9ba3e, bc1e2acc:
  - `AES_data_in`=000000c0_00000000_00000000_00000000, `AES_key_in`=aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  - `AES_en` rises the cycle after word 7;
  - pulse `AES_data_out_valid` at hold count 20, and `AES_en` falls after that edge.
- After the test above, `key_reuse`=1 and 4 words a6f2daeb, 140fa720, 529e75d5, 21cbc681:
  - RUN entered after the 4th word;
  - key unchanged, `AES_data_in`=a6f2daeb_140fa720_529e75d5_21cbc681.
- No valid ever returned (EN_HOLD_MAX=64):
  - `AES_en` high exactly 64 cycles, then `timeout_err`=1 and `wr_ready`=1;
  - `err_clr` for one cycle returns `timeout_err` to 0.
- `AES_data_out_valid` asserted on the same edge as the timeout:
  - `timeout_err` stays 0;
  - valid asserted during LOAD has no effect on state.
- `key_reuse`=1 right after reset: 8 words are still required and the key is loaded from words 4-7.
- Assert `AES_rst_n` low mid-load (after 5 words) and mid-RUN:
  - `AES_en` falls asynchronously and all outputs return to 0;
  - the following load needs 8 words.
